// File: rtl/scan_misr.sv
// rtl/scan_misr.sv - scan load/capture sequencer with 16-bit MISR over two scan chains
// Optional golden-signature comparator: define SCAN_MISR_GOLDEN_CMP_EN.
module scan_misr #(
  parameter int          CHAIN_LEN    = 32,
  parameter int          NUM_PATTERNS = 64,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  scan_out,
  output logic        scan_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        pass
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] SHIFT_LAST = 8'(CHAIN_LEN - 1);
  localparam logic [9:0] PAT_LAST   = 10'(NUM_PATTERNS - 1);

  state_t      state, state_nx;
  logic [7:0]  shift_cnt, shift_cnt_nx;
  logic [9:0]  pat_cnt, pat_cnt_nx;
  logic [15:0] sig_nx;

  // CCITT polynomial feedback, chain outputs folded into the two low bits
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [1:0] d);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {14'b0, d};
  endfunction

  always_comb begin
    state_nx     = state;
    shift_cnt_nx = shift_cnt;
    pat_cnt_nx   = pat_cnt;
    sig_nx       = signature;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx     = SHIFT;
          shift_cnt_nx = 8'd0;
          pat_cnt_nx   = 10'd0;
          sig_nx       = 16'h0000;
        end
      end
      SHIFT: begin
        sig_nx = misr_next(signature, scan_out);
        if (shift_cnt == SHIFT_LAST) begin
          shift_cnt_nx = 8'd0;
          state_nx     = CAPTURE;
        end else begin
          shift_cnt_nx = shift_cnt + 8'd1;
        end
      end
      CAPTURE: begin
        pat_cnt_nx = pat_cnt + 10'd1;
        state_nx   = (pat_cnt == PAT_LAST) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        sig_nx = misr_next(signature, scan_out);
        if (shift_cnt == SHIFT_LAST) begin
          shift_cnt_nx = 8'd0;
          state_nx     = DONE;
        end else begin
          shift_cnt_nx = shift_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_cnt <= 8'd0;
      pat_cnt   <= 10'd0;
      signature <= 16'h0000;
      scan_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      shift_cnt <= shift_cnt_nx;
      pat_cnt   <= pat_cnt_nx;
      signature <= sig_nx;
      scan_en   <= (state_nx == SHIFT) || (state_nx == UNLOAD);
      busy      <= (state_nx == SHIFT) || (state_nx == CAPTURE) || (state_nx == UNLOAD);
      done      <= (state_nx == DONE);
    end
  end

`ifdef SCAN_MISR_GOLDEN_CMP_EN
  // Verdict latched on DONE entry from the final signature, dropped on exit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass <= 1'b0;
    end else if (state_nx != DONE) begin
      pass <= 1'b0;
    end else if (state != DONE) begin
      pass <= (sig_nx == GOLDEN_SIG);
    end
  end
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN_SIG;
  assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_scan_misr.sv
// tb/tb_scan_misr.sv - self-checking bench for scan_misr (two configurations, shared stimulus)
module tb_scan_misr;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  scan_out = 2'b00;
  logic [1:0]  en_v, busy_v, done_v, pass_v;
  logic [15:0] sig_v [2];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  scan_misr #(.CHAIN_LEN(4), .NUM_PATTERNS(2), .GOLDEN_SIG(16'h0000)) u_a (
    .clock(clock), .reset(reset), .start(start), .scan_out(scan_out),
    .scan_en(en_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .signature(sig_v[0]), .pass(pass_v[0])
  );

  scan_misr #(.CHAIN_LEN(8), .NUM_PATTERNS(2), .GOLDEN_SIG(16'h0001)) u_b (
    .clock(clock), .reset(reset), .start(start), .scan_out(scan_out),
    .scan_en(en_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .signature(sig_v[1]), .pass(pass_v[1])
  );

  function automatic int cl_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic logic [15:0] gold_of(input int i);
    return (i == 0) ? 16'h0000 : 16'h0001;
  endfunction

  function automatic int total_of(input int i);
    return 2 * (cl_of(i) + 1) + cl_of(i);
  endfunction

  // Cycle k of a session shifts unless it is the last cycle of a pattern period
  function automatic bit shifting(input int k, input int cl);
    if (k >= 2 * (cl + 1)) return 1'b1;
    return (k % (cl + 1)) != cl;
  endfunction

  function automatic logic [15:0] step(input logic [15:0] s, input logic [1:0] d);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {14'b0, d};
  endfunction

  bit          m_act  [2];
  bit          m_done [2];
  int          m_k    [2];
  logic [15:0] m_sig  [2];

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_k[i]    <= 0;
        m_sig[i]  <= 16'h0000;
      end else if (!m_act[i] && start) begin
        m_act[i]  <= 1'b1;
        m_done[i] <= 1'b0;
        m_k[i]    <= 0;
        m_sig[i]  <= 16'h0000;
      end else if (m_act[i]) begin
        if (shifting(m_k[i], cl_of(i))) m_sig[i] <= step(m_sig[i], scan_out);
        if (m_k[i] == total_of(i) - 1) begin
          m_act[i]  <= 1'b0;
          m_done[i] <= 1'b1;
        end
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic exp_pass;
`ifdef SCAN_MISR_GOLDEN_CMP_EN
      exp_pass = m_done[i] && (m_sig[i] == gold_of(i));
`else
      exp_pass = 1'b0;
`endif
      chk($sformatf("busy%0d", i), {31'b0, busy_v[i]}, {31'b0, m_act[i]});
      chk($sformatf("done%0d", i), {31'b0, done_v[i]}, {31'b0, m_done[i]});
      chk($sformatf("scan_en%0d", i), {31'b0, en_v[i]},
          {31'b0, m_act[i] && shifting(m_k[i], cl_of(i))});
      chk($sformatf("signature%0d", i), {16'b0, sig_v[i]}, {16'b0, m_sig[i]});
      chk($sformatf("pass%0d", i), {31'b0, pass_v[i]}, {31'b0, exp_pass});
    end
  end

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done_v[i] && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("wait_done%0d", i), {31'b0, done_v[i]}, 32'd1);
  endtask

  task automatic count_busy(output int n, output logic [31:0] pat);
    n   = 0;
    pat = 32'b0;
    while (busy_v[0] && n < 40) begin
      pat = {pat[30:0], en_v[0]};
      n++;
      @(negedge clock);
    end
  endtask

  task automatic misr_run(input logic [1:0] v, input logic [15:0] exp);
    int n = 0;
    @(negedge clock); start = 1'b1; scan_out = 2'b00;
    @(negedge clock); start = 1'b0; scan_out = 2'b01;
    chk("sig_cleared", {16'b0, sig_v[0]}, 32'h0);
    @(negedge clock); scan_out = 2'b00;
    chk("sig_a_1", {16'b0, sig_v[0]}, 32'h0001);
    chk("sig_b_1", {16'b0, sig_v[1]}, 32'h0001);
    @(negedge clock);
    chk("sig_a_2", {16'b0, sig_v[0]}, 32'h0002);
    chk("sig_b_2", {16'b0, sig_v[1]}, 32'h0002);
    while (sig_v[1] != 16'h8000 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("sig_b_8000", {16'b0, sig_v[1]}, 32'h8000);
    chk("capture_en_b", {31'b0, en_v[1]}, 32'd0);
    scan_out = v;
    @(negedge clock);
    chk("capture_hold_b", {16'b0, sig_v[1]}, 32'h8000);
    @(negedge clock);
    chk("feedback_b", {16'b0, sig_v[1]}, {16'b0, exp});
    scan_out = 2'b00;
    wait_done(1, 40);
  endtask

  initial begin
    int          n;
    logic [31:0] pat;

    repeat (3) @(negedge clock);
    chk("rst_busy", {31'b0, busy_v[0]}, 32'd0);
    chk("rst_sig", {16'b0, sig_v[0]}, 32'h0);
    chk("rst_en", {31'b0, en_v[0]}, 32'd0);
    chk("rst_done", {31'b0, done_v[0]}, 32'd0);
    reset = 1'b0;

    // All-zero session on the 4x2 instance
    pulse_start();
    count_busy(n, pat);
    chk("busy_len", n, 32'd14);
    chk("en_pattern", pat, 32'b11110111101111);
    chk("zero_sig", {16'b0, sig_v[0]}, 32'h0);
    chk("zero_done", {31'b0, done_v[0]}, 32'd1);
`ifdef SCAN_MISR_GOLDEN_CMP_EN
    chk("pass_a", {31'b0, pass_v[0]}, 32'd1);
`else
    chk("pass_a", {31'b0, pass_v[0]}, 32'd0);
`endif
    wait_done(1, 40);
    chk("pass_b", {31'b0, pass_v[1]}, 32'd0);

    // MISR step and feedback vectors
    misr_run(2'b00, 16'h1021);
    misr_run(2'b11, 16'h1022);

    // start during SHIFT and CAPTURE is ignored
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (busy_v[0] && n < 40) begin
      start    = (n == 1) || (n == 4);
      scan_out = 2'(n);
      if (n == 4) chk("capture_en_a", {31'b0, en_v[0]}, 32'd0);
      n++;
      @(negedge clock);
    end
    start    = 1'b0;
    scan_out = 2'b00;
    chk("ignored_len", n, 32'd14);

    // start in DONE restarts with a cleared signature
    pulse_start();
    chk("restart_busy", {31'b0, busy_v[0]}, 32'd1);
    chk("restart_sig", {16'b0, sig_v[0]}, 32'h0);
    wait_done(0, 40);
    wait_done(1, 40);

    // Reset in cycle 6 aborts the session
    pulse_start();
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy_v[0]}, 32'd0);
    chk("abort_sig", {16'b0, sig_v[0]}, 32'h0);
    chk("abort_en", {31'b0, en_v[0]}, 32'd0);
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_idle", {31'b0, busy_v[0] | done_v[0]}, 32'd0);
    pulse_start();
    count_busy(n, pat);
    chk("after_abort_len", n, 32'd14);
    chk("after_abort_done", {31'b0, done_v[0]}, 32'd1);
    wait_done(1, 40);
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_misr.md
SCAN_MISR -- requirements
Module: scan_misr

Interface
REQ-001 Parameter CHAIN_LEN, default 32: scan shift cycles per pattern (range 2..255).
REQ-002 Parameter NUM_PATTERNS, default 64: load/capture iterations per session (range 1..1023).
REQ-003 Parameter GOLDEN_SIG, default 16'h0000: expected final signature.
REQ-004 clock  input  1  single rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle session request; honoured only in IDLE or DONE.
REQ-007 scan_out  input  2  scan-chain outputs of the circuit under test (chain 0 = bit 0).
REQ-008 scan_en  output  1  shift enable driven to the CUT scan-select input.
REQ-009 busy  output  1  high while in SHIFT, CAPTURE or UNLOAD.
REQ-010 done  output  1  high while in DONE.
REQ-011 signature  output  16  current MISR contents.
REQ-012 pass  output  1  signature == GOLDEN_SIG, valid only while done=1 (see REQ-030).

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, CAPTURE, UNLOAD, DONE; all outputs registered.
REQ-014 IDLE/DONE + start=1 -> SHIFT next cycle; signature, shift counter and pattern counter cleared on that edge.
REQ-015 SHIFT SHALL last exactly CHAIN_LEN cycles with scan_en=1, then go to CAPTURE.
REQ-016 CAPTURE SHALL last exactly 1 cycle with scan_en=0; pattern counter increments on exit.
REQ-017 CAPTURE exit: if pattern counter was NUM_PATTERNS-1 -> UNLOAD, else -> SHIFT.
REQ-018 UNLOAD SHALL last CHAIN_LEN cycles with scan_en=1, then -> DONE.
REQ-019 Session length from first SHIFT cycle to first DONE cycle SHALL be NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN cycles.
REQ-020 MISR SHALL update on every clock edge where state is SHIFT or UNLOAD; it SHALL hold in CAPTURE, IDLE and DONE.
REQ-021 MISR update: t = {sig[14:0],1'b0}; if sig[15]=1 then t = t ^ 16'h1021; sig_next = t ^ {14'b0, scan_out}.
REQ-022 scan_out SHALL be sampled on the same edge the MISR updates; no input pipeline stage.
REQ-023 start while busy=1 SHALL be ignored (no restart, no counter effect).
REQ-024 start in DONE SHALL restart a fresh session per REQ-014.
REQ-025 DONE SHALL persist (done=1, signature frozen) until start or reset.
REQ-026 scan_en SHALL be 0 in IDLE, CAPTURE and DONE.
REQ-027 Counters SHALL be sized for the parameter maxima (8-bit shift, 10-bit pattern); no wrap within a session.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, counters 0, signature 16'h0000, scan_en=0, busy=0, done=0, pass=0.
REQ-029 reset asserted mid-session SHALL abort the session; after release the block waits in IDLE for start.

Configuration
REQ-030 Macro SCAN_MISR_GOLDEN_CMP_EN defined: pass is registered, set on the cycle DONE is entered to (signature==GOLDEN_SIG), held through DONE, cleared on leaving DONE.
REQ-031 Macro undefined: comparator omitted, pass tied to 0; all other behaviour identical.

Verification
REQ-032 CHAIN_LEN=4, NUM_PATTERNS=2, scan_out=2'b00 throughout, start pulse -> busy high 14 cycles, scan_en pattern 1111 0 1111 0 1111, signature 16'h0000, done=1.
REQ-033 From cleared MISR in SHIFT: scan_out=2'b01 one cycle then 2'b00 -> signature 16'h0001 then 16'h0002.
REQ-034 MISR holding 16'h8000 in SHIFT with scan_out=2'b00 -> next signature 16'h1021; with scan_out=2'b11 -> 16'h1022.
REQ-035 Reset pulsed at cycle 6 of a CHAIN_LEN=4, NUM_PATTERNS=2 session -> immediate IDLE, signature 0, scan_en 0; new start completes normally in 14 cycles.
REQ-036 start pulsed during SHIFT and CAPTURE -> ignored, session length unchanged; start in DONE -> new session with signature cleared.
REQ-037 With SCAN_MISR_GOLDEN_CMP_EN, GOLDEN_SIG=16'h0000 and REQ-032 stimulus -> pass=1 in DONE; GOLDEN_SIG=16'h0001 -> pass=0.
